// File: rtl/open_collector_pkg.sv
// Shared encodings for the open-collector transmit arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package open_collector_pkg;

  // Frame sequencer states; each non-idle state spans whole bit periods.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GUARD
  } state_t;

  // Line levels of the framing bits (line level equals bit value).
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Bit periods in one frame: start + payload + stop.
  function automatic int frame_bits(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Picks the first asserted request searching cyclically from ptr+1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module round_robin_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx
);

  logic [PW-1:0] cand;

  // Walk from the lowest priority candidate up so the last hit is the winner.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = PW'((int'(ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/open_collector_tx_arbiter.sv
// Round-robin owner of a shared wired-AND line; serialises start/data/stop, aborts on collision.
// Latency: grant and start bit drive one cycle after REQ seen with the line idle.
// Backpressure: requesters wait while BUSY or the line is held low; REQ must stay up until DONE/COLL.
module open_collector_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*DATA_W-1:0] DATA,
  input  logic                      LINE,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [NUM_REQ-1:0]        DONE,
  output logic                      COLL,
  output logic                      BUSY,
  output logic                      OC_DIN
);
  import open_collector_pkg::*;

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                coll_q, coll_d;
  logic                busy_q, busy_d;
  logic                oc_din_q, oc_din_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       win_q, win_d;

  logic [NUM_REQ-1:0]  rr_gnt;
  logic [PW-1:0]       rr_idx;
  logic                bit_end;
  logic                collide;

  round_robin_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_rr (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  // Frame sequencing: grant, bit timing, shifting, collision abort, guard gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    coll_d   = 1'b0;
    busy_d   = busy_q;
    oc_din_d = oc_din_q;
    ptr_d    = ptr_q;
    win_d    = win_q;

    bit_end = (cnt_q == CNT_LAST);
    // We released the line (bit 1) yet someone else holds it low.
    collide = bit_end && !oc_din_q && !LINE;

    case (state_q)
      ST_IDLE: begin
        if (|REQ && LINE) begin
          state_d  = ST_START;
          cnt_d    = '0;
          gnt_d    = rr_gnt;
          win_d    = rr_idx;
          shift_d  = DATA[rr_idx*DATA_W +: DATA_W];
          busy_d   = 1'b1;
          oc_din_d = ~START_BIT;
        end
      end

      ST_START, ST_DATA, ST_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (collide) begin
          // Pointer left alone so the same requester retries first.
          coll_d   = 1'b1;
          gnt_d    = '0;
          oc_din_d = 1'b0;
          state_d  = ST_GUARD;
        end else if (bit_end) begin
          if (state_q == ST_START) begin
            state_d  = ST_DATA;
            idx_d    = '0;
            oc_din_d = ~shift_q[0];
            shift_d  = shift_q >> 1;
          end else if (state_q == ST_DATA) begin
            if (idx_q == IDX_LAST) begin
              state_d  = ST_STOP;
              oc_din_d = ~STOP_BIT;
            end else begin
              idx_d    = idx_q + 1'b1;
              oc_din_d = ~shift_q[0];
              shift_d  = shift_q >> 1;
            end
          end else begin
            done_d   = gnt_q;
            gnt_d    = '0;
            ptr_d    = win_q;
            oc_din_d = 1'b0;
            state_d  = ST_GUARD;
          end
        end
      end

      ST_GUARD: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        gnt_d    = '0;
        busy_d   = 1'b0;
        oc_din_d = 1'b0;
      end
    endcase
  end

  // State register; reset releases the line and makes requester 0 highest priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      coll_q   <= 1'b0;
      busy_q   <= 1'b0;
      oc_din_q <= 1'b0;
      ptr_q    <= PW'(NUM_REQ - 1);
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      coll_q   <= coll_d;
      busy_q   <= busy_d;
      oc_din_q <= oc_din_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
    end
  end

  assign GNT    = gnt_q;
  assign DONE   = done_q;
  assign COLL   = coll_q;
  assign BUSY   = busy_q;
  assign OC_DIN = oc_din_q;

endmodule

// File: tb/tb_open_collector_tx_arbiter.sv
// Directed bench for open_collector_tx_arbiter with a table of whole frames plus corner sequences.
// Latency: checks grant one cycle after request and DONE after 40 granted cycles.
// Backpressure: the line model is the wired-AND of this transmitter and a forced-low override.
module tb_open_collector_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic        line;
  logic        force_low;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        coll;
  logic        busy;
  logic        oc_din;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       rst_before;
    logic [3:0] req;
    logic [3:0] exp_gnt;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[8];

  assign line = ~(oc_din | force_low);

  always #5 clk = ~clk;

  open_collector_tx_arbiter #(
    .NUM_REQ    (4),
    .DATA_W     (8),
    .BIT_CYCLES (4)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .REQ    (req),
    .DATA   (data),
    .LINE   (line),
    .GNT    (gnt),
    .DONE   (done),
    .COLL   (coll),
    .BUSY   (busy),
    .OC_DIN (oc_din)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_outs", 32'({gnt, done, coll, busy, oc_din}), 32'd0);
  endtask

  // Follows one full frame starting from the negedge before the grant edge.
  task automatic check_frame(input logic [3:0] eg, input logic [7:0] eb,
                             input int drop_c, input string tag);
    logic [9:0] got;
    logic [9:0] expv;
    logic       gnt_bad;
    logic       done_bad;
    got      = '0;
    gnt_bad  = 1'b0;
    done_bad = 1'b0;
    // OC_DIN per bit period: start pulls low, data inverted LSB first, stop released.
    expv = {1'b0, ~eb, 1'b1};
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == drop_c) req = '0;
      if (c == 1) begin
        chk($sformatf("%s.gnt", tag), 32'(gnt), 32'(eg));
        chk($sformatf("%s.busy_on", tag), 32'(busy), 32'd1);
      end
      if (c <= 40) begin
        if (gnt !== eg) gnt_bad = 1'b1;
        if (done !== 4'b0) done_bad = 1'b1;
        if (c % 4 == 2) got = {oc_din, got[9:1]};
      end
      if (c == 41) begin
        chk($sformatf("%s.done", tag), 32'(done), 32'(eg));
        chk($sformatf("%s.gnt_clr", tag), 32'({gnt, oc_din}), 32'd0);
      end
      if (c == 42) chk($sformatf("%s.done_pulse", tag), 32'(done), 32'd0);
      if (c == 44) chk($sformatf("%s.busy_guard", tag), 32'(busy), 32'd1);
      if (c == 45) chk($sformatf("%s.busy_off", tag), 32'(busy), 32'd0);
    end
    chk($sformatf("%s.gnt_held", tag), 32'(gnt_bad), 32'd0);
    chk($sformatf("%s.no_early_done", tag), 32'(done_bad), 32'd0);
    chk($sformatf("%s.bits", tag), 32'(got), 32'(expv));
  endtask

  initial begin
    logic flag_a;
    logic flag_b;

    rst       = 1'b1;
    req       = '0;
    force_low = 1'b0;
    data      = {8'h3C, 8'h96, 8'h5A, 8'hA5};

    vecs[0] = '{1'b1, 4'b0001, 4'b0001, 8'hA5};
    vecs[1] = '{1'b1, 4'b1111, 4'b0001, 8'hA5};
    vecs[2] = '{1'b0, 4'b1111, 4'b0010, 8'h5A};
    vecs[3] = '{1'b0, 4'b1111, 4'b0100, 8'h96};
    vecs[4] = '{1'b0, 4'b1111, 4'b1000, 8'h3C};
    vecs[5] = '{1'b0, 4'b1111, 4'b0001, 8'hA5};
    vecs[6] = '{1'b0, 4'b1010, 4'b0010, 8'h5A};
    vecs[7] = '{1'b0, 4'b1001, 4'b1000, 8'h3C};

    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rst_before) do_reset();
      req = vecs[v].req;
      check_frame(vecs[v].exp_gnt, vecs[v].exp_byte, 0, $sformatf("vec%0d", v));
    end

    // Collision during data bit 3 of an all-ones byte.
    do_reset();
    data[7:0] = 8'hFF;
    req       = 4'b0011;
    flag_a    = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done !== 4'b0) flag_a = 1'b1;
      if (c == 1) chk("coll.gnt", 32'(gnt), 32'b0001);
      if (c == 17) force_low = 1'b1;
      if (c == 20) chk("coll.not_yet", 32'({gnt, coll}), 32'b00010);
      if (c == 21) begin
        chk("coll.pulse", 32'(coll), 32'd1);
        chk("coll.release", 32'({gnt, oc_din, busy}), 32'b000001);
        force_low = 1'b0;
      end
      if (c == 22) chk("coll.one_cycle", 32'(coll), 32'd0);
      if (c == 25) chk("coll.busy_off", 32'(busy), 32'd0);
    end
    chk("coll.no_done", 32'(flag_a), 32'd0);
    check_frame(4'b0001, 8'hFF, 0, "retry");
    data[7:0] = 8'hA5;

    // Line held low by another station while idle.
    do_reset();
    force_low = 1'b1;
    req       = 4'b0001;
    flag_b    = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (gnt !== 4'b0 || busy !== 1'b0) flag_b = 1'b1;
    end
    chk("busy_line.no_gnt", 32'(flag_b), 32'd0);
    force_low = 1'b0;
    @(negedge clk);
    chk("busy_line.gnt", 32'({gnt, busy, oc_din}), 32'b000111);

    // Reset in the middle of data bit 4.
    do_reset();
    req = 4'b0011;
    repeat (22) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.outs", 32'({gnt, done, coll, busy, oc_din}), 32'd0);
    rst = 1'b0;
    check_frame(4'b0001, 8'hA5, 0, "after_rst");

    // Requester drops REQ during data bit 2; frame still completes, no regrant.
    do_reset();
    req = 4'b0100;
    check_frame(4'b0100, 8'h96, 14, "drop");
    flag_b = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (gnt !== 4'b0 || busy !== 1'b0) flag_b = 1'b1;
    end
    chk("drop.no_regrant", 32'(flag_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/open_collector_tx_arbiter.md
Name: open_collector_tx_arbiter

Overview:
Shares one wired-AND open-collector serial line between NUM_REQ requesters. Round-robin arbitration runs while the line is idle. The block serialises the winner's byte as start, data and stop bits and drives the open_collector_encoder DIN input (1 = pull line low). It reads the line back and aborts on collision, so several arbiters can coexist on one line.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 8, bits per frame payload
BIT_CYCLES, 16, CLK cycles per bit period (>=2)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
REQ  in  NUM_REQ  requester i has a byte pending; sampled only in IDLE
DATA  in  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]; captured at grant
LINE  in  1  bus level readback, already synchronised (1 = released/high)
GNT  out  NUM_REQ  one-hot owner of current frame
DONE  out  NUM_REQ  one-cycle pulse, frame of requester i completed without collision
COLL  out  1  one-cycle pulse, frame aborted on collision
BUSY  out  1  high from START entry through end of GUARD
OC_DIN  out  1  to open_collector_encoder DIN; 1 = pull line low

Behaviour:
- Reset: state IDLE; GNT=0, DONE=0, COLL=0, BUSY=0, OC_DIN=0; RR pointer=NUM_REQ-1 (requester 0 highest priority). Reset mid-frame releases the line on the next edge, with no DONE/COLL.
- Line coding: line level = bit value; OC_DIN = ~bit. Start bit = 0. Data is sent LSB first. Stop bit = 1.
- States: IDLE -> START -> DATA -> STOP -> GUARD -> IDLE. Each bit state lasts BIT_CYCLES. DATA lasts DATA_W bit periods. GUARD lasts BIT_CYCLES with OC_DIN=0.
- IDLE:
  - Grant only if |REQ and LINE==1 in the same cycle.
  - Winner = first set REQ searching from pointer+1 cyclically.
  - Next edge: GNT=onehot(winner), BUSY=1, OC_DIN=1 (start), winner's DATA latched into shift register. Latency is 1 cycle.
- GNT is held for exactly (DATA_W+2)*BIT_CYCLES cycles and cleared entering GUARD.
- REQ changes during a frame are ignored. A requester must keep REQ high until DONE or COLL if it wants the byte sent.
- Sample point is the last cycle of each bit period (bit counter == BIT_CYCLES-1), in START/DATA/STOP.
  - Collision = OC_DIN==0 and LINE==0 at the sample point.
  - On collision: next edge COLL=1 for one cycle, GNT=0, OC_DIN=0, go to GUARD. Pointer is unchanged, so the same requester retries first.
- Successful STOP end: DONE[winner]=1 for one cycle (same edge GNT clears), pointer=winner, go to GUARD.
- GUARD -> IDLE. BUSY drops on the GUARD-to-IDLE edge. A new grant is possible the following cycle.
- Counters:
  - Bit-cycle counter: clog2(BIT_CYCLES) bits, wraps to 0 at BIT_CYCLES-1.
  - Bit index: clog2(DATA_W) bits.
  - No arithmetic overflow paths beyond these wraps.
- OC_DIN is registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package/header open_collector_pkg:
  - state encoding (IDLE, START, DATA, STOP, GUARD)
  - START_BIT=0, STOP_BIT=1
  - FRAME_BITS=DATA_W+2
- Sub-module round_robin_arbiter (NUM_REQ): inputs REQ and pointer; outputs one-hot grant and encoded index. Purely combinational.
- The top level holds the FSM, counters, shift register and collision check.

Test Plan:
(NUM_REQ=4, DATA_W=8, BIT_CYCLES=4, LINE = ~OC_DIN unless forced)
1. Single frame: REQ=0001, DATA0=0xA5.
   -> GNT=0001 one cycle later.
   -> OC_DIN per bit: 1 | 0,1,0,1,1,0,1,0 | 0.
   -> DONE[0] pulse after 40 cycles of GNT.
   -> BUSY low 4 cycles later.
2. Round robin: REQ=1111 held, distinct bytes.
   -> grant order 0,1,2,3,0.
   -> each frame is 40 GNT cycles plus 4 GUARD cycles.
3. Collision: DATA0=0xFF, force LINE=0 during data bit 3.
   -> COLL pulse after bit-3 sample, GNT=0, OC_DIN=0, no DONE.
   -> next grant is requester 0.
4. Busy line: REQ=0001 with LINE forced 0 in IDLE.
   -> no GNT.
   -> release LINE -> GNT=0001 on next edge.
5. Reset mid-frame: RST for 1 cycle during data bit 4, REQ=0011 held.
   -> next edge all outputs 0.
   -> after release: GNT=0001, full 40-cycle frame.
6. REQ drop: requester deasserts REQ in data bit 2.
   -> frame completes unchanged.
   -> DONE pulses.
   -> no re-grant.
